access_code_correlator: RTL and testbench

// Receive-side sliding correlator for the 64-bit sync word. It sits directly upstream of the header bit processor.
// It shifts in one rxbit per p_1us strobe and scores each 64-bit window against the expected sync word (CAC/DAC/IAC, selected by the caller).
// On a hit it produces rx_trailer_st_p, which starts the receive header/trailer counting downstream.

---
 rtl/access_code_correlator_if.sv | 31 +++
 rtl/access_code_correlator.sv | 111 +++++++++++
 tb/tb_access_code_correlator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/access_code_correlator_if.sv
// access_code_correlator_if
//   Groups the correlator's strobe/data inputs, search control, configuration
//   and result outputs. clk/rst stay plain ports on the module.
//   master: the caller (drives p_1us, rxbit, search_*, regi_*)
//   slave : the correlator (drives rx_trailer_st_p, corr_*, searching)
interface access_code_correlator_if #(
  parameter int SYNC_W = 64,
  parameter int WIN_W  = 16,
  parameter int SC_W   = $clog2(SYNC_W + 1)
);
  logic              p_1us;
  logic              rxbit;
  logic              search_en;
  logic [WIN_W-1:0]  search_win;
  logic [SYNC_W-1:0] regi_syncword;
  logic [SC_W-1:0]   regi_corr_thresh;
  logic              rx_trailer_st_p;
  logic              corr_timeout_p;
  logic              corr_hit;
  logic              searching;
  logic [SC_W-1:0]   corr_score;

  modport master (
    output p_1us, rxbit, search_en, search_win, regi_syncword, regi_corr_thresh,
    input  rx_trailer_st_p, corr_timeout_p, corr_hit, searching, corr_score
  );
  modport slave (
    input  p_1us, rxbit, search_en, search_win, regi_syncword, regi_corr_thresh,
    output rx_trailer_st_p, corr_timeout_p, corr_hit, searching, corr_score
  );
endinterface

// File: rtl/access_code_correlator.sv
// access_code_correlator
//   Sliding correlator for the 64-bit sync word. One rxbit is shifted in per
//   p_1us strobe while searching; each 64-bit window is scored against the
//   expected sync word. A hit arms the trailer start pulse for the next strobe;
//   an expired search window without a hit gives a timeout pulse instead.
// Ports
//   clk_6M : 6 MHz system clock
//   rst    : synchronous reset, active-high
//   bus    : access_code_correlator_if.slave
//            in : p_1us, rxbit, search_en, search_win, regi_syncword,
//                 regi_corr_thresh
//            out: rx_trailer_st_p (hit pulse, coincident with a strobe),
//                 corr_timeout_p, corr_hit (LOCKED), searching
//                 (SEARCH/HIT_PEND), corr_score (last agreement count)
module access_code_correlator #(
  parameter int SYNC_W = 64,
  parameter int WIN_W  = 16
) (
  input logic                      clk_6M,
  input logic                      rst,
  access_code_correlator_if.slave  bus
);
  localparam int SC_W = $clog2(SYNC_W + 1);

  typedef enum logic [2:0] {IDLE, SEARCH, HIT_PEND, LOCKED, DONE} st_t;

  st_t               st_q;
  logic [SYNC_W-1:0] sr_q;
  logic [SC_W-1:0]   fill_q;
  logic [SC_W-1:0]   score_q;
  logic [SC_W-1:0]   score_d;
  logic [WIN_W-1:0]  win_q;
  logic              bnd_q;      // window is bounded (search_win != 0 at start)
  logic              to_q;
  // [0]: score update cycle, [1]: hit/expiry evaluation cycle
  logic [1:0]        vld_pipe;
  logic              hit;

  // Agreement count of the current window against the expected word.
  always_comb begin
    score_d = '0;
    for (int i = 0; i < SYNC_W; i++)
      score_d = score_d + SC_W'(sr_q[i] == bus.regi_syncword[i]);
  end

  // Fill guard keeps a partially filled register from matching (thresh=0 case).
  assign hit = (fill_q == SC_W'(SYNC_W)) && (score_q >= bus.regi_corr_thresh);

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      st_q     <= IDLE;
      sr_q     <= '0;
      fill_q   <= '0;
      score_q  <= '0;
      win_q    <= '0;
      bnd_q    <= 1'b0;
      to_q     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      to_q     <= 1'b0;
      vld_pipe <= {vld_pipe[0], 1'b0};
      if (vld_pipe[0]) score_q <= score_d;

      if (!bus.search_en) begin
        // Abort from any state; a pending hit is dropped silently.
        st_q     <= IDLE;
        sr_q     <= '0;
        fill_q   <= '0;
        score_q  <= '0;
        win_q    <= '0;
        bnd_q    <= 1'b0;
        vld_pipe <= '0;
      end else begin
        case (st_q)
          IDLE: begin
            st_q  <= SEARCH;
            win_q <= bus.search_win;
            bnd_q <= (bus.search_win != '0);
          end
          SEARCH: begin
            if (bus.p_1us) begin
              sr_q     <= {sr_q[SYNC_W-2:0], bus.rxbit};
              vld_pipe <= {vld_pipe[0], 1'b1};
              if (fill_q != SC_W'(SYNC_W)) fill_q <= fill_q + 1'b1;
              if (bnd_q && win_q != '0) win_q <= win_q - 1'b1;
            end
            // Hit is tested first so it wins over expiry on the same bit.
            if (vld_pipe[1]) begin
              if (hit) begin
                st_q <= HIT_PEND;
              end else if (bnd_q && win_q == '0) begin
                to_q <= 1'b1;
                st_q <= DONE;
              end
            end
          end
          HIT_PEND: if (bus.p_1us) st_q <= LOCKED;
          default: st_q <= st_q;   // LOCKED/DONE hold until search_en drops
        endcase
      end
    end
  end

  // Trailer pulse must coincide with the strobe itself, so it is decoded from
  // the registered state; gating with rst/search_en suppresses it on abort.
  assign bus.rx_trailer_st_p = (st_q == HIT_PEND) && bus.p_1us && bus.search_en && !rst;
  assign bus.corr_timeout_p  = to_q;
  assign bus.corr_hit        = (st_q == LOCKED);
  assign bus.searching       = (st_q == SEARCH) || (st_q == HIT_PEND);
  assign bus.corr_score      = score_q;
endmodule

// File: tb/tb_access_code_correlator.sv
module tb_access_code_correlator;
  localparam logic [63:0] SW = 64'h4E7A_1C93_D205_B86F;

  logic clk_6M = 1'b0;
  logic rst;
  always #5 clk_6M = ~clk_6M;

  access_code_correlator_if ifc ();
  access_code_correlator dut (.clk_6M(clk_6M), .rst(rst), .bus(ifc));

  int n_pass = 0, n_tot = 0;
  int strobe_n = 0;
  int trl_cnt = 0, trl_strobe = 0, to_cnt = 0, to_strobe = 0;
  logic trl_coinc = 1'b0;
  logic stim[$];

  always @(posedge clk_6M) begin
    if (ifc.rx_trailer_st_p) begin
      trl_cnt    <= trl_cnt + 1;
      trl_strobe <= strobe_n;
      trl_coinc  <= ifc.p_1us;
    end
    if (ifc.corr_timeout_p) begin
      to_cnt    <= to_cnt + 1;
      to_strobe <= strobe_n;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One bit per 6 clocks, strobe one clock wide.
  task automatic strobe(input logic b);
    @(negedge clk_6M);
    ifc.p_1us = 1'b1; ifc.rxbit = b; strobe_n++;
    @(negedge clk_6M);
    ifc.p_1us = 1'b0;
    repeat (4) @(negedge clk_6M);
  endtask

  // Reference: agreement of the 64 most recent bits (zeros before the start)
  // with the sync word, bit j of the word pairing with the bit j strobes ago.
  function automatic int score_at(input int n, input logic [63:0] sw);
    int cnt = 0;
    for (int j = 0; j < 64; j++) begin
      logic b = (n - 1 - j >= 0) ? stim[n-1-j] : 1'b0;
      if (b == sw[j]) cnt++;
    end
    return cnt;
  endfunction

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'($urandom));
  endtask

  task automatic add_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) stim.push_back(w[i]);
  endtask

  task automatic start(input logic [63:0] sw, input int th, input int win);
    @(negedge clk_6M);
    ifc.regi_syncword = sw; ifc.regi_corr_thresh = 7'(th);
    ifc.search_win = 16'(win); ifc.search_en = 1'b1; strobe_n = 0;
    @(negedge clk_6M);
  endtask

  task automatic drop_and_check(input string tag);
    ifc.search_en = 1'b0;
    @(negedge clk_6M);
    chk({tag, "_idle_searching"}, ifc.searching, 0);
    chk({tag, "_idle_hit"}, ifc.corr_hit, 0);
    chk({tag, "_idle_score"}, ifc.corr_score, 0);
  endtask

  // Full search over the stim queue, checked against the model.
  task automatic run_search(input string tag, input logic [63:0] sw, input int th, input int win);
    int exp_hit = -1, exp_to = -1, last = stim.size(), t0 = trl_cnt, o0 = to_cnt;
    for (int n = 1; n <= stim.size(); n++) begin
      if (n >= 64 && score_at(n, sw) >= th) begin exp_hit = n; last = n; break; end
      if (win != 0 && n == win) begin exp_to = n; last = n; break; end
    end
    start(sw, th, win);
    for (int i = 0; i < stim.size(); i++) strobe(stim[i]);
    chk({tag, "_trl_cnt"}, trl_cnt - t0, (exp_hit >= 0) ? 1 : 0);
    chk({tag, "_to_cnt"}, to_cnt - o0, (exp_to >= 0) ? 1 : 0);
    if (exp_hit >= 0) begin
      chk({tag, "_trl_strobe"}, trl_strobe, exp_hit + 1);
      chk({tag, "_trl_coinc"}, trl_coinc, 1);
    end
    if (exp_to >= 0) chk({tag, "_to_strobe"}, to_strobe, exp_to);
    chk({tag, "_score"}, ifc.corr_score, score_at(last, sw));
    chk({tag, "_hit"}, ifc.corr_hit, (exp_hit >= 0) ? 1 : 0);
    chk({tag, "_searching"}, ifc.searching, (exp_hit < 0 && exp_to < 0) ? 1 : 0);
    drop_and_check(tag);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    ifc.p_1us = 0; ifc.rxbit = 0; ifc.search_en = 0; ifc.search_win = '0;
    ifc.regi_syncword = SW; ifc.regi_corr_thresh = 7'd64;
    repeat (3) @(negedge clk_6M);
    chk("rst_trl", ifc.rx_trailer_st_p, 0);
    chk("rst_to", ifc.corr_timeout_p, 0);
    chk("rst_hit", ifc.corr_hit, 0);
    chk("rst_searching", ifc.searching, 0);
    chk("rst_score", ifc.corr_score, 0);
    rst = 1'b0;

    // T1: exact word after random preamble
    stim.delete(); add_rand(80); add_word(SW); add_rand(1);
    run_search("t1", SW, 64, 0);

    // T2: 4 flips at threshold 60 hits, 5 flips does not
    stim.delete(); add_rand(10); add_word(SW ^ 64'h8000_0100_0010_0001); add_rand(1);
    run_search("t2a", SW, 60, 0);
    stim.delete(); add_rand(10); add_word(SW ^ 64'h8000_0100_0010_0003);
    run_search("t2b", SW, 60, 0);

    // T3: bounded window, no match
    stim.delete(); add_rand(110);
    run_search("t3", SW, 64, 100);

    // T4: thresh 0 hits only once the register is full
    stim.delete(); add_rand(70);
    run_search("t4", SW, 0, 0);

    // T5a: abort mid-SEARCH
    t0 = trl_cnt + to_cnt;
    start(SW, 64, 0);
    for (int i = 0; i < 30; i++) strobe(1'($urandom));
    chk("t5a_searching", ifc.searching, 1);
    drop_and_check("t5a");
    // T5b: abort mid-HIT_PEND, then a strobe must not pulse
    start(SW, 64, 0);
    for (int i = 63; i >= 0; i--) strobe(SW[i]);
    chk("t5b_pend_searching", ifc.searching, 1);
    chk("t5b_pend_score", ifc.corr_score, 64);
    drop_and_check("t5b");
    strobe(1'b0);
    chk("t5_no_pulses", trl_cnt + to_cnt - t0, 0);

    // T6a: rst while HIT_PEND, strobe during rst
    t0 = trl_cnt + to_cnt;
    start(SW, 64, 0);
    for (int i = 63; i >= 0; i--) strobe(SW[i]);
    rst = 1'b1;
    strobe(1'b1);
    chk("t6a_hit", ifc.corr_hit, 0);
    chk("t6a_searching", ifc.searching, 0);
    chk("t6a_score", ifc.corr_score, 0);
    chk("t6a_to", ifc.corr_timeout_p, 0);
    chk("t6a_no_pulses", trl_cnt + to_cnt - t0, 0);
    ifc.search_en = 1'b0;
    @(negedge clk_6M);
    rst = 1'b0;
    // T6b: match on the final window bit, hit wins
    stim.delete(); add_word(SW); add_rand(1);
    run_search("t6b", SW, 64, 64);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
